// File: rtl/adiabatic_phase_sequencer.sv
// Sequencer for multi-phase trapezoidal power clocks: per-phase state code and
// step-wise charging level, staggered start-up, drain-to-low on stop, period count.
module adiabatic_phase_sequencer #(
    parameter int NPH = 4,
    parameter int LW  = 4,
    parameter int PCW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [LW-1:0]       cfg_qlen,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [2*NPH-1:0]    ph_state,
    output logic [LW*NPH-1:0]   ph_level,
    output logic [PCW-1:0]      periods
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [LW-1:0]     qlen_q, qlen_d;
    logic [LW-1:0]     step_q, step_d;
    logic [1:0]        q_q, q_d;
    logic [NPH-1:0]    active_q, active_d;
    logic [PCW-1:0]    periods_q, periods_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [2*NPH-1:0]  ph_state_q, ph_state_d;
    logic [LW*NPH-1:0] ph_level_q, ph_level_d;
    logic              boundary;

    function automatic logic [LW-1:0] phase_level(input logic [1:0]    s,
                                                  input logic [LW-1:0] stp,
                                                  input logic [LW-1:0] ql);
        case (s)
            2'd0:    return stp + LW'(1);
            2'd1:    return ql;
            2'd2:    return ql - LW'(1) - stp;
            default: return '0;
        endcase
    endfunction

    assign boundary = (step_q == qlen_q - LW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q      <= S_IDLE;
            qlen_q     <= '0;
            step_q     <= '0;
            q_q        <= '0;
            active_q   <= '0;
            periods_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ph_state_q <= '1;
            ph_level_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            qlen_q     <= qlen_d;
            step_q     <= step_d;
            q_q        <= q_d;
            active_q   <= active_d;
            periods_q  <= periods_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ph_state_q <= ph_state_d;
            ph_level_q <= ph_level_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            S_IDLE:  if (start && cfg_qlen != '0) fsm_d = S_RUN;
            S_RUN:   if (stop) fsm_d = S_DRAIN;
            S_DRAIN: if (boundary && active_d == '0) fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    // Quadrant counters; activation at RUN boundaries, retirement as a phase leaves FALL in DRAIN.
    always_comb begin
        qlen_d    = qlen_q;
        step_d    = step_q;
        q_d       = q_q;
        active_d  = active_q;
        periods_d = periods_q;
        if (fsm_q == S_IDLE) begin
            if (start && cfg_qlen != '0) begin
                qlen_d      = cfg_qlen;
                step_d      = '0;
                q_d         = '0;
                active_d    = '0;
                active_d[0] = 1'b1;
                periods_d   = '0;
            end
        end else begin
            if (boundary) begin
                step_d = '0;
                q_d    = q_q + 2'd1;
                if (q_q == 2'd3) periods_d = periods_q + PCW'(1);
            end else begin
                step_d = step_q + LW'(1);
            end
            for (int k = 0; k < NPH; k++) begin
                if (boundary && fsm_q == S_RUN && !stop && q_d == 2'(k))
                    active_d[k] = 1'b1;
                if (boundary && fsm_q == S_DRAIN && active_q[k] && (q_q - 2'(k)) == 2'd2)
                    active_d[k] = 1'b0;
            end
        end
    end

    // Outputs are computed from next-cycle state so they leave the flops aligned with it.
    always_comb begin
        busy_d     = (fsm_d != S_IDLE);
        done_d     = (fsm_q == S_DRAIN) && (fsm_d == S_IDLE);
        err_d      = (fsm_q == S_IDLE) && start && (cfg_qlen == '0);
        ph_state_d = '1;
        ph_level_d = '0;
        for (int k = 0; k < NPH; k++) begin
            if (active_d[k]) begin
                ph_state_d[2*k +: 2]   = q_d - 2'(k);
                ph_level_d[LW*k +: LW] = phase_level(q_d - 2'(k), step_d, qlen_d);
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign ph_state = ph_state_q;
    assign ph_level = ph_level_q;
    assign periods  = periods_q;

endmodule

// File: tb/tb_adiabatic_phase_sequencer.sv
// Directed bench with a time-based phase model checked every cycle plus literal waveform pins.
module tb_adiabatic_phase_sequencer;
    localparam int NPH = 4;
    localparam int LW  = 4;
    localparam int PCW = 16;

    logic                clk = 1'b0;
    logic                rst_n, start, stop;
    logic [LW-1:0]       cfg_qlen;
    logic                busy, done, err;
    logic [2*NPH-1:0]    ph_state;
    logic [LW*NPH-1:0]   ph_level;
    logic [PCW-1:0]      periods;

    int n_total = 0;
    int n_pass  = 0;

    adiabatic_phase_sequencer #(.NPH(NPH), .LW(LW), .PCW(PCW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cfg_qlen(cfg_qlen),
        .busy(busy), .done(done), .err(err), .ph_state(ph_state),
        .ph_level(ph_level), .periods(periods)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Model: t counts cycles since RUN began; phase k runs on local time t - k*qlen.
    int  m_mode;   // 0 idle, 1 run, 2 drain
    int  m_t, m_qlen, m_per;
    bit  m_act[NPH];
    bit  m_done, m_err, m_valid = 0;

    always @(posedge clk) begin
        int  tn;
        bit  all_off;
        m_valid = 1;
        if (!rst_n) begin
            m_mode = 0; m_t = 0; m_qlen = 0; m_per = 0; m_done = 0; m_err = 0;
            for (int k = 0; k < NPH; k++) m_act[k] = 0;
        end else begin
            m_done = 0; m_err = 0;
            if (m_mode == 0) begin
                if (start && cfg_qlen == 0) m_err = 1;
                else if (start) begin
                    m_mode = 1; m_qlen = int'(cfg_qlen); m_t = 0; m_per = 0;
                    for (int k = 0; k < NPH; k++) m_act[k] = (k == 0);
                end
            end else begin
                tn = m_t + 1;
                if (tn % (4 * m_qlen) == 0) m_per++;
                for (int k = 0; k < NPH; k++) begin
                    if (m_mode == 1 && !stop && tn == k * m_qlen) m_act[k] = 1;
                    if (m_mode == 2 && m_act[k] && tn % m_qlen == 0 &&
                        ((tn - k * m_qlen) / m_qlen) % 4 == 3) m_act[k] = 0;
                end
                m_t = tn;
                all_off = 1;
                for (int k = 0; k < NPH; k++) if (m_act[k]) all_off = 0;
                if (m_mode == 1 && stop) m_mode = 2;
                else if (m_mode == 2 && all_off) begin m_mode = 0; m_done = 1; end
            end
        end
    end

    logic [2*NPH-1:0]  e_state;
    logic [LW*NPH-1:0] e_level;
    always @(negedge clk) begin
        int u, qd, w, lv;
        if (m_valid) begin
            e_state = '1;
            e_level = '0;
            for (int k = 0; k < NPH; k++) begin
                if (m_act[k]) begin
                    u  = m_t - k * m_qlen;
                    qd = (u / m_qlen) % 4;
                    w  = u % m_qlen;
                    lv = (qd == 0) ? w + 1 : (qd == 1) ? m_qlen : (qd == 2) ? m_qlen - 1 - w : 0;
                    e_state[2*k +: 2]   = 2'(qd);
                    e_level[LW*k +: LW] = LW'(lv);
                end
            end
            check("busy", busy, m_mode != 0);
            check("done", done, m_done);
            check("err", err, m_err);
            check("periods", periods, PCW'(m_per));
            check("ph_state", ph_state, e_state);
            check("ph_level", ph_level, e_level);
        end
    end

    initial begin
        int lit_up[13];
        int lit_es[6];
        bit seen;
        int lat;
        lit_up = '{1, 2, 3, 3, 3, 3, 2, 1, 0, 0, 0, 0, 1};
        lit_es = '{1, 2, 2, 2, 1, 0};
        rst_n = 0; start = 0; stop = 0; cfg_qlen = 0;
        repeat (2) @(negedge clk);
        check("rst_state", ph_state, 8'hFF);
        check("rst_level", ph_level, 16'h0);
        check("rst_busy", busy, 0);
        check("rst_periods", periods, 0);
        rst_n = 1;
        @(negedge clk);

        // Rejected start
        cfg_qlen = 0; start = 1;
        @(negedge clk);
        start = 0;
        check("rej_err", err, 1);
        check("rej_busy", busy, 0);
        check("rej_state", ph_state, 8'hFF);
        @(negedge clk);
        check("rej_err_clear", err, 0);

        // Start-up waveform, qlen=3; later cfg changes must be ignored
        cfg_qlen = 3; start = 1;
        @(negedge clk);
        start = 0; cfg_qlen = 7;
        for (int i = 0; i < 13; i++) begin
            check("up_ph0_level", ph_level[3:0], LW'(lit_up[i]));
            if (i == 3)  check("up_ph1_first", ph_level[7:4], 1);
            if (i == 9)  check("up_ph3_first", ph_level[15:12], 1);
            if (i == 8)  check("up_ph3_idle", ph_level[15:12], 0);
            if (i == 11) check("up_periods0", periods, 0);
            if (i == 12) check("up_periods1", periods, 1);
            @(negedge clk);
        end
        @(negedge clk);
        // Graceful stop at RUN cycle 14
        stop = 1;
        @(negedge clk);
        stop = 0;
        seen = 0; lat = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done) begin seen = 1; lat = c; end
            else @(negedge clk);
        end
        check("drain_done_seen", seen, 1);
        check("drain_latency_le12", lat <= 12, 1);
        check("drain_busy", busy, 0);
        check("drain_levels", ph_level, 16'h0);
        @(negedge clk);
        check("drain_done_once", done, 0);
        check("drain_state", ph_state, 8'hFF);

        // Early stop, qlen=2
        cfg_qlen = 2; start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 6; i++) begin
            check("es_ph0_level", ph_level[3:0], LW'(lit_es[i]));
            check("es_others_low", ph_state[7:2], 6'h3F);
            if (i == 1) stop = 1;
            if (i == 2) stop = 0;
            @(negedge clk);
        end
        check("es_done", done, 1);
        check("es_busy", busy, 0);
        @(negedge clk);

        // Mid-run reset then restart
        cfg_qlen = 3; start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        check("mr_nonzero", ph_level != 0, 1);
        rst_n = 0;
        @(negedge clk);
        check("mr_levels", ph_level, 16'h0);
        check("mr_busy", busy, 0);
        check("mr_state", ph_state, 8'hFF);
        rst_n = 1; cfg_qlen = 2; start = 1;
        @(negedge clk);
        start = 0;
        check("mr_restart_level", ph_level, 16'h0001);
        check("mr_restart_state", ph_state, 8'hFC);
        check("mr_restart_busy", busy, 1);
        repeat (5) @(negedge clk);
        stop = 1;
        @(negedge clk);
        stop = 0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done) seen = 1;
            else @(negedge clk);
        end
        check("mr_final_done", seen, 1);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/adiabatic_phase_sequencer.md
Name: adiabatic_phase_sequencer

Overview:
- Digital controller that sequences the multi-phase trapezoidal power clocks feeding the adiabatic logic cells (clkpos/clkpos2/clkneg/clkneg2 rails).
- For each phase it emits a 2-bit state code and a step-wise charging level; an analog step-charger/switch bank consumes these codes.
- Provides staggered start-up, graceful drain-to-low on stop, and a completed-period counter.
- Sits between the test/control interface and the power-clock driver for the MIPS25 adiabatic datapath.

Parameters:
- NPH, 4, number of power-clock phases; phase k lags phase k-1 by one quadrant.
- LW, 4, width of the charging-level code and of cfg_qlen.
- PCW, 16, width of the completed-period counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  start request; sampled in IDLE only.
- stop  input  1  stop request; sampled in RUN only.
- cfg_qlen  input  LW  quadrant length in clk cycles (1..2^LW-1); latched at accepted start.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  one-cycle pulse when DRAIN completes.
- err  output  1  one-cycle pulse when a start is rejected (cfg_qlen==0).
- ph_state  output  2*NPH  per-phase state, phase k at [2k+1:2k]: 0=RISE, 1=HIGH, 2=FALL, 3=LOW.
- ph_level  output  LW*NPH  per-phase charging level, phase k at [LW*k+LW-1:LW*k].
- periods  output  PCW  completed full periods (quadrant index wraps 3->0), wraps at 2^PCW.

Behaviour:
- Reset (rst_n=0 at an edge): FSM=IDLE; busy=0, done=0, err=0, all ph_state=3 (LOW), all ph_level=0, periods=0, step=0, q=0, active=0. Reset mid-RUN/DRAIN forces these values at the next edge with no drain; this abrupt drop is the required behaviour.
- All outputs are registered.
- FSM states: IDLE, RUN, DRAIN.
- IDLE, start=1, cfg_qlen!=0: next cycle RUN; qlen is latched; step=0, q=0, active={0..01}; periods is cleared.
- IDLE, start=1, cfg_qlen==0: remain in IDLE; err pulses for 1 cycle.
- In IDLE, stop is ignored.
- Counters run in RUN and DRAIN:
  - step increments each cycle.
  - When step==qlen-1 (boundary): step=0 and q=q+1 mod 4.
  - When q wraps 3->0, periods increments.
- Phase k state when active is S=(q-k) mod 4.
  - RISE: level = step+1.
  - HIGH: level = qlen.
  - FALL: level = qlen-1-step.
  - LOW: level = 0.
- An inactive phase outputs state LOW, level 0.
- Activation: only in RUN. At a boundary where the new q equals k, phase k becomes active, so phase k first shows RISE, level 1, k*qlen cycles after phase 0.
- RUN, stop=1: next cycle DRAIN. Counters continue; no further activations.
- DRAIN: an active phase is deactivated at the boundary where it leaves FALL, so its level reaches 0 naturally.
- DRAIN completion: when the active set becomes empty at a boundary, the next state is IDLE, done=1 for 1 cycle and busy=0 on that same cycle. Outputs then hold LOW/0.
- A phase never activated stays inactive during DRAIN.
- If stop is asserted before phase 1 activates, only phase 0 drains.
- qlen=1: every quadrant is one cycle; levels alternate 1,1,0,0.
- cfg_qlen changes after start are ignored until the next accepted start.
- start in RUN or DRAIN is ignored; stop in DRAIN is ignored.
- Maximum drain latency: 4*qlen cycles after entering DRAIN.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles -> all ph_state=3, ph_level=0, busy=0, periods=0.
- Start-up waveform: NPH=4, cfg_qlen=3, start pulse.
  - Phase 0 ph_level from the first RUN cycle is 1,2,3,3,3,3,2,1,0,0,0,0,1,...
  - Phase 1 shows level 1 at RUN cycle 3; phase 3 at cycle 9.
  - periods=1 at cycle 12.
- Reject start: cfg_qlen=0 with start -> err high for exactly 1 cycle, busy stays 0, outputs unchanged.
- Graceful stop: qlen=3, all phases active, assert stop.
  - Each phase completes its FALL to level 0 before going quiet.
  - done pulses once, within 12 cycles of DRAIN entry.
  - Final state has all levels 0 and busy=0.
- Early stop: qlen=2, stop at RUN cycle 1.
  - Phases 1-3 are never activated.
  - Phase 0 shows 1,2,2,2,1,0, then done.
- Mid-run reset: rst_n=0 during RUN with levels nonzero -> next edge all levels 0, state IDLE; a subsequent start restarts from phase 0 only.
